// File: rtl/bubble_sort_seq_if.sv
// Valid/ready load and drain streams of the bubble-sort engine.
interface bubble_sort_seq_if #(
  parameter int unsigned W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/bubble_sort_seq.sv
// Sequential bubble sort: load N signed words, sort with one shared
// compare-exchange per clock (early exit on a clean pass), stream out ascending.
module bubble_sort_seq #(
  parameter int unsigned N = 9,
  parameter int unsigned W = 32
) (
  input  logic              clk,
  input  logic              rst,
  bubble_sort_seq_if.slave  bus,
  output logic              busy,
  output logic [15:0]       sort_cycles
);

  localparam int unsigned IW   = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned LAST = N - 1;

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  state_t               state_q, state_d;
  logic signed [W-1:0]  a [N];
  logic [IW-1:0]        ld_idx, i, j, rd_idx;
  logic                 swapped;

  logic                 swap_c, last_cmp_c, sort_done_c;
  logic [IW-1:0]        i_nxt_c;

  // Shared compare-exchange unit and end-of-pass decision
  assign i_nxt_c     = i + IW'(1);
  assign swap_c      = a[i] > a[i_nxt_c];
  assign last_cmp_c  = (i == j - IW'(1));
  assign sort_done_c = last_cmp_c && (!(swapped || swap_c) || (j == IW'(1)));

  // Next state and outputs, decoded from registered state only
  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_last  = 1'b0;
    busy          = 1'b0;
    case (state_q)
      LOAD: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid && (ld_idx == IW'(LAST))) begin
          state_d = (N == 1) ? DRAIN : SORT;
        end
      end
      SORT: begin
        busy = 1'b1;
        if (sort_done_c) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        bus.out_data  = a[rd_idx];
        bus.out_last  = (rd_idx == IW'(LAST));
        if (bus.out_ready && (rd_idx == IW'(LAST))) begin
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // State register, storage array and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD;
      for (int k = 0; k < int'(N); k++) a[k] <= '0;
      ld_idx      <= '0;
      i           <= '0;
      j           <= '0;
      rd_idx      <= '0;
      swapped     <= 1'b0;
      sort_cycles <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        LOAD: begin
          if (bus.in_valid) begin
            a[ld_idx] <= bus.in_data;
            if (ld_idx == IW'(LAST)) begin
              ld_idx  <= '0;
              rd_idx  <= '0;
              i       <= '0;
              j       <= IW'(LAST);
              swapped <= 1'b0;
              if (N > 1) sort_cycles <= '0;
            end else begin
              ld_idx <= ld_idx + IW'(1);
            end
          end
        end
        SORT: begin
          if (swap_c) begin
            a[i]       <= a[i_nxt_c];
            a[i_nxt_c] <= a[i];
          end
          if (sort_cycles != 16'hFFFF) sort_cycles <= sort_cycles + 16'd1;
          swapped <= swapped || swap_c;
          if (last_cmp_c) begin
            if (sort_done_c) begin
              rd_idx <= '0;
            end else begin
              j       <= j - IW'(1);
              i       <= '0;
              swapped <= 1'b0;
            end
          end else begin
            i <= i_nxt_c;
          end
        end
        DRAIN: begin
          if (bus.out_ready) begin
            rd_idx <= (rd_idx == IW'(LAST)) ? '0 : rd_idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/bubble_sort_seq.md
# bubble_sort_seq

Sequential bubble-sort engine: it accepts a list of N signed words over a valid/ready input stream, sorts it in place, and streams the result back out in ascending order. One compare-exchange unit is shared across all array positions, and a controller sequences it with one compare per clock. Sorting stops early after a pass with no swaps. The block sits between a producer and a consumer that both use valid/ready handshakes.

## Interface
- N, 9: list length; legal range N ≥ 1.
- W, 32: data width; values are two's-complement signed.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  producer has a word on in_data.
- in_ready  out  1  block accepts a word this cycle.
- in_data  in  W  input word.
- out_valid  out  1  out_data holds a sorted element.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  W  sorted element, ascending order; driven 0 when out_valid=0.
- out_last  out  1  marks element N-1 of the output stream.
- busy  out  1  high in SORT and DRAIN states.
- sort_cycles  out  16  compare count of the most recent sort.

## Operation
- Storage: array a[0..N-1] of W-bit signed values, plus counters ld_idx, i, j, rd_idx, a swapped flag, and a cycle counter.
- States: LOAD, SORT, DRAIN. Reset state is LOAD.
- LOAD:
  - in_ready=1.
  - On in_valid&&in_ready, write a[ld_idx]=in_data and increment ld_idx.
  - On the Nth accept: if N=1, go to DRAIN; otherwise go to SORT with i=0, j=N-1, swapped=0, sort_cycles=0.
- SORT:
  - in_ready=0.
  - Each cycle, compare a[i] with a[i+1] using signed comparison.
  - If a[i]>a[i+1], swap the two and set swapped. Equal values are never swapped, so the sort is stable.
  - Increment sort_cycles by 1 every SORT cycle; it saturates at 16'hFFFF.
  - If i<j-1: increment i.
  - If i==j-1 (last compare of the pass):
    - If no swap occurred in this pass, including this cycle, or j==1: go to DRAIN with rd_idx=0.
    - Otherwise: j=j-1, i=0, swapped=0.
- DRAIN:
  - out_valid=1, out_data=a[rd_idx], out_last=(rd_idx==N-1).
  - On out_valid&&out_ready, increment rd_idx.
  - On acceptance of the last element, go to LOAD with ld_idx=0.
  - out_data is held stable while out_ready=0.
- sort_cycles holds its value from the end of SORT until the next SORT entry.
- Input and output never overlap: in_ready and out_valid are never both high.
- Reset, at any time including mid-LOAD, mid-SORT or mid-DRAIN:
  - All array entries and counters are cleared to 0; state goes to LOAD.
  - Any partial list is discarded.

## Timing
- Output values during and after reset: in_ready=1 (state LOAD), out_valid=0, out_data=0, out_last=0, busy=0, sort_cycles=0.
  - in_ready is high immediately after reset deasserts.
- All outputs are decoded from registered state. No combinational path from in_valid or out_ready to any output.
- The Nth input accept happens at edge t. The first compare occurs during cycle t+1.
- If the last compare is in the cycle ending at edge u, out_valid=1 from edge u.
- SORT latency:
  - Minimum N-1 cycles (already-sorted input).
  - Maximum N(N-1)/2 cycles (reverse-sorted input).
  - N=9: range 8..36.
- DRAIN takes N cycles when out_ready is held high.
- in_ready returns 1 in the cycle after the last output handshake.
- Back-to-back lists reach full throughput, limited only by the SORT phase.

## Test plan
- Load {9,1,5,8,3,6,11,7,4}, out_ready=1 → output 1,3,4,5,6,7,8,9,11; out_last on 11; sort_cycles=35 (early exit after the 7th pass); in_ready=0 throughout SORT and DRAIN.
- Load already-sorted {1,2,...,9} → sort_cycles=8; output is identical to input.
- Load reverse-sorted {9,8,...,1} → sort_cycles=36; output 1..9.
- Load signed values with duplicates {0,-1,5,-1,32'h7FFFFFFF,32'h80000000,5,0,3} → output 32'h80000000,-1,-1,0,0,3,5,5,32'h7FFFFFFF.
- During DRAIN, toggle out_ready randomly, holding it low for 3 cycles at rd_idx=4 → out_data stays stable at the 5th element while stalled; no element is lost or duplicated; exactly 9 handshakes occur.
- Assert rst during SORT (sort_cycles=10) → next cycle: state LOAD, in_ready=1, busy=0, sort_cycles=0. Then load {2,1,...} → the new list sorts correctly with no residue from the aborted list.
